// File: rtl/ppm_frame_ctrl.sv
// ppm_frame_ctrl
// Frame-level sequencer for the 4-PPM receive path, running on the 16x
// oversampling clock. Detects the start-of-frame low pulse on the raw line,
// enables the 2-bit symbol decoder, packs four symbols (MSB-first) into each
// byte, checks the length byte and reports clean completion or error.
//
// Ports
//   clk16      in   oversampling clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   din        in   raw PPM line (idle high, pulses low)
//   abort      in   synchronous request to drop the current frame
//   sym_valid  in   one-cycle pulse per decoded symbol
//   sym_data   in   [1:0] symbol bits, [2] symbol error flag
//   dec_en     out  enable to the symbol decoder
//   byte_out   out  last assembled payload byte (held)
//   byte_valid out  one-cycle strobe, byte_out updated
//   len_out    out  received length byte
//   frame_done out  one-cycle strobe, frame completed cleanly
//   frame_err  out  one-cycle strobe, frame dropped on error
//   busy       out  high whenever the sequencer is not idle
module ppm_frame_ctrl #(
    parameter int SOF_MIN     = 6,
    parameter int SOF_MAX     = 12,
    parameter int SYM_TIMEOUT = 16,
    parameter int MAX_BYTES   = 16
) (
    input  logic                        clk16,
    input  logic                        rst_n,
    input  logic                        din,
    input  logic                        abort,
    input  logic                        sym_valid,
    input  logic [2:0]                  sym_data,
    output logic                        dec_en,
    output logic [7:0]                  byte_out,
    output logic                        byte_valid,
    output logic [$clog2(MAX_BYTES):0]  len_out,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int LOW_W = $clog2(SOF_MAX + 1);
    localparam int GAP_W = $clog2(SYM_TIMEOUT + 1);
    localparam int LEN_W = $clog2(MAX_BYTES) + 1;

    localparam logic [LOW_W-1:0] LOW_MIN  = LOW_W'(SOF_MIN);
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(SOF_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYM_TIMEOUT - 1);
    localparam logic [7:0]       LEN_MAX  = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [LOW_W-1:0]   low_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   byte_cnt;
    logic [1:0]         sym_cnt;
    logic [5:0]         shift;
    logic               wait_high;
    logic [7:0]         packed_val;
    logic               sym_bad;

    // The three previously received symbols plus the one arriving now.
    assign packed_val = {shift, sym_data[1:0]};
    assign sym_bad    = sym_valid & sym_data[2];

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dec_en     <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            len_out    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            low_cnt    <= '0;
            gap_cnt    <= '0;
            byte_cnt   <= '0;
            sym_cnt    <= '0;
            shift      <= '0;
            wait_high  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // After a stuck-line fault the line must go high again
                    // before another SOF can be recognised.
                    if (din) begin
                        wait_high <= 1'b0;
                    end
                    if (!din && !wait_high) begin
                        state   <= S_SOF;
                        low_cnt <= LOW_W'(1);
                        busy    <= 1'b1;
                    end
                end

                S_SOF: begin
                    if (abort) begin
                        state     <= S_ERR;
                        dec_en    <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (!din) begin
                        if (low_cnt == LOW_LAST) begin
                            state     <= S_ERR;
                            dec_en    <= 1'b0;
                            frame_err <= 1'b1;
                            wait_high <= 1'b1;
                        end else begin
                            low_cnt <= low_cnt + 1'b1;
                        end
                    end else if (low_cnt < LOW_MIN) begin
                        // Too short to be an SOF: silently back to idle.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_LEN;
                        dec_en  <= 1'b1;
                        gap_cnt <= '0;
                        sym_cnt <= '0;
                        shift   <= '0;
                    end
                end

                S_LEN, S_DATA: begin
                    // Priority: abort, frame complete, symbol error, clean
                    // symbol, timeout. A clean symbol clears the gap counter,
                    // so it always beats a coincident timeout.
                    if (abort) begin
                        state     <= S_ERR;
                        dec_en    <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (state == S_DATA && byte_cnt == len_out) begin
                        state      <= S_DONE;
                        dec_en     <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (sym_bad) begin
                        state     <= S_ERR;
                        dec_en    <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (sym_valid) begin
                        gap_cnt <= '0;
                        sym_cnt <= sym_cnt + 1'b1;
                        shift   <= {shift[3:0], sym_data[1:0]};
                        if (sym_cnt == 2'd3) begin
                            if (state == S_LEN) begin
                                if (packed_val == 8'd0 || packed_val > LEN_MAX) begin
                                    state     <= S_ERR;
                                    dec_en    <= 1'b0;
                                    frame_err <= 1'b1;
                                end else begin
                                    len_out  <= packed_val[LEN_W-1:0];
                                    byte_cnt <= '0;
                                    state    <= S_DATA;
                                end
                            end else begin
                                byte_out   <= packed_val;
                                byte_valid <= 1'b1;
                                byte_cnt   <= byte_cnt + 1'b1;
                            end
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        state     <= S_ERR;
                        dec_en    <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    dec_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// Testbench for ppm_frame_ctrl: frames are described as SOF length plus a
// list of symbol slots (gap before the symbol, value, error flag, optional
// abort). A frame-level reference model turns the description into the list
// of expected output events; a monitor compares DUT strobes against it.
module tb_ppm_frame_ctrl;

    localparam int NSLOT = 68;

    localparam int EV_BYTE = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    localparam int K_NONE    = 0;
    localparam int K_GLITCH  = 1;
    localparam int K_STUCK   = 2;
    localparam int K_TIMEOUT = 3;
    localparam int K_ABORT   = 4;
    localparam int K_SERR    = 5;
    localparam int K_BADLEN  = 6;
    localparam int K_DONE    = 7;

    logic       clk16 = 1'b0;
    logic       rst_n;
    logic       din;
    logic       abort;
    logic       sym_valid;
    logic [2:0] sym_data;
    logic       dec_en;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [4:0] len_out;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    always #5 clk16 = ~clk16;

    ppm_frame_ctrl dut (
        .clk16      (clk16),
        .rst_n      (rst_n),
        .din        (din),
        .abort      (abort),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .dec_en     (dec_en),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .len_out    (len_out),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_byte_cyc = -100;

    int  f_sof;
    int  f_sym [NSLOT];
    int  f_gap [NSLOT];
    bit  f_serr[NSLOT];
    int  f_abort_slot;
    bit  f_abort_sym;
    int  stop_slot;
    int  stop_kind;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_dec_en"},     int'(dec_en), 0);
        chk({tag, "_byte_out"},   int'(byte_out), 0);
        chk({tag, "_byte_valid"}, int'(byte_valid), 0);
        chk({tag, "_len_out"},    int'(len_out), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_err"},  int'(frame_err), 0);
        chk({tag, "_busy"},       int'(busy), 0);
    endtask

    // Monitor: every output strobe must match the head of the expected queue.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk16);
            #1;
            cyc++;
            if (!rst_n) continue;
            if (byte_valid || frame_done || frame_err) begin
                chk("one_strobe", int'(byte_valid) + int'(frame_done) + int'(frame_err), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: bv=%0d done=%0d err=%0d expected none",
                             byte_valid, frame_done, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    if (byte_valid) begin
                        chk("event_kind_byte", EV_BYTE, e.kind);
                        chk("byte_value", int'(byte_out), e.val);
                        last_byte_cyc = cyc;
                    end else if (frame_done) begin
                        chk("event_kind_done", EV_DONE, e.kind);
                        chk("len_out", int'(len_out), e.val);
                        chk("done_after_last_byte", cyc - last_byte_cyc, 1);
                        chk("dec_en_at_done", int'(dec_en), 0);
                        chk("busy_at_done", int'(busy), 1);
                    end else begin
                        chk("event_kind_err", EV_ERR, e.kind);
                        chk("dec_en_at_err", int'(dec_en), 0);
                        chk("busy_at_err", int'(busy), 1);
                    end
                end
            end
        end
    end

    // Frame-level reference model: walks the symbol slots applying the
    // frame rules and records the expected events and where the frame ends.
    task automatic model_frame();
        int len;
        int acc;
        int nbytes;
        stop_slot = -1;
        stop_kind = K_NONE;
        if (f_sof < 6) begin
            stop_kind = K_GLITCH;
            return;
        end
        if (f_sof >= 12) begin
            push_ev(EV_ERR, 0);
            stop_kind = K_STUCK;
            return;
        end
        acc = 0;
        len = 0;
        nbytes = 0;
        for (int i = 0; i < NSLOT; i++) begin
            stop_slot = i;
            if (f_gap[i] >= 16) begin
                push_ev(EV_ERR, 0);
                stop_kind = K_TIMEOUT;
                return;
            end
            if (f_abort_slot == i) begin
                push_ev(EV_ERR, 0);
                stop_kind = K_ABORT;
                return;
            end
            if (f_serr[i]) begin
                push_ev(EV_ERR, 0);
                stop_kind = K_SERR;
                return;
            end
            acc = acc * 4 + f_sym[i];
            if (i % 4 == 3) begin
                if (i == 3) begin
                    len = acc;
                    if (len == 0 || len > 16) begin
                        push_ev(EV_ERR, 0);
                        stop_kind = K_BADLEN;
                        return;
                    end
                end else begin
                    push_ev(EV_BYTE, acc);
                    nbytes++;
                    if (nbytes == len) begin
                        push_ev(EV_DONE, len);
                        stop_kind = K_DONE;
                        return;
                    end
                end
                acc = 0;
            end
        end
    endtask

    task automatic drive_frame();
        bit accepted;
        accepted = (f_sof >= 6 && f_sof < 12);
        @(negedge clk16);
        din = 1'b0;
        repeat (f_sof) @(negedge clk16);
        if (accepted) chk("dec_en_before_sof_end", int'(dec_en), 0);
        if (f_sof >= 14) begin
            chk("stuck_no_resync_busy", int'(busy), 0);
            chk("stuck_no_resync_dec_en", int'(dec_en), 0);
        end
        din = 1'b1;
        @(posedge clk16);
        #1;
        chk("dec_en_after_sof", int'(dec_en), int'(accepted));
        if (accepted) chk("busy_in_frame", int'(busy), 1);
        if (stop_kind == K_GLITCH) begin
            chk("glitch_busy", int'(busy), 0);
            chk("glitch_frame_err", int'(frame_err), 0);
        end
        if (!accepted) return;
        for (int i = 0; i <= stop_slot; i++) begin
            repeat (f_gap[i]) begin
                @(negedge clk16);
                sym_valid = 1'b0;
            end
            if (i == stop_slot && stop_kind == K_TIMEOUT) break;
            @(negedge clk16);
            if (i == stop_slot && stop_kind == K_ABORT) begin
                abort     = 1'b1;
                sym_valid = f_abort_sym;
                sym_data  = {1'b0, 2'(f_sym[i])};
                @(posedge clk16);
                #1;
                chk("abort_err_next_cycle", int'(frame_err), 1);
                @(negedge clk16);
                abort     = 1'b0;
                sym_valid = 1'b0;
                break;
            end
            sym_valid = 1'b1;
            sym_data  = {f_serr[i], 2'(f_sym[i])};
        end
        @(negedge clk16);
        sym_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(posedge clk16);
            #1;
            if (exp_q.size() == 0 && !busy) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL frame_end: pending=%0d busy=%0d expected pending=0 busy=0",
                         exp_q.size(), busy);
                exp_q.delete();
                break;
            end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk16);
    endtask

    task automatic new_frame(int sof);
        f_sof        = sof;
        f_abort_slot = -1;
        f_abort_sym  = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            f_sym[i]  = $urandom_range(0, 3);
            f_gap[i]  = $urandom_range(0, 2);
            f_serr[i] = 1'b0;
        end
    endtask

    task automatic set_len(int v);
        for (int k = 0; k < 4; k++) f_sym[k] = (v >> (6 - 2 * k)) & 3;
    endtask

    task automatic run_frame();
        model_frame();
        drive_frame();
        wait_idle();
    endtask

    initial begin
        int r;
        rst_n     = 1'b0;
        din       = 1'b1;
        abort     = 1'b0;
        sym_valid = 1'b0;
        sym_data  = 3'b000;
        repeat (3) @(posedge clk16);
        #1;
        chk_all_zero("reset");
        @(negedge clk16);
        rst_n = 1'b1;
        repeat (2) @(negedge clk16);

        // Abort in idle is ignored.
        abort = 1'b1;
        @(posedge clk16);
        #1;
        chk("idle_abort_busy", int'(busy), 0);
        @(negedge clk16);
        abort = 1'b0;

        // Clean frame: length 2, bytes 0xE4 and 0x1B, zero gaps.
        new_frame(8);
        for (int i = 0; i < NSLOT; i++) f_gap[i] = 0;
        set_len(2);
        f_sym[4] = 3; f_sym[5] = 2; f_sym[6] = 1; f_sym[7] = 0;
        f_sym[8] = 0; f_sym[9] = 1; f_sym[10] = 2; f_sym[11] = 3;
        run_frame();

        // SOF length boundaries.
        new_frame(3);  run_frame();
        new_frame(5);  run_frame();
        new_frame(6);  set_len(1); run_frame();
        new_frame(11); set_len(1); run_frame();
        new_frame(12); run_frame();
        new_frame(20); run_frame();
        new_frame(7);  set_len(1); run_frame();

        // Symbol error mid-byte and on the final symbol.
        new_frame(8); set_len(1); f_serr[6] = 1'b1; run_frame();
        new_frame(8); set_len(1); f_serr[7] = 1'b1; run_frame();

        // Timeout after one byte, and the largest gap that still passes,
        // including on the final symbol.
        new_frame(8); set_len(3); f_gap[8] = 16; run_frame();
        new_frame(8); set_len(2); f_gap[8] = 15; f_gap[11] = 15; f_gap[4] = 15; run_frame();

        // Abort mid-byte, and abort coinciding with the final symbol.
        new_frame(8); set_len(3); f_abort_slot = 9; f_abort_sym = 1'b1; run_frame();
        new_frame(9); set_len(1); f_abort_slot = 7; f_abort_sym = 1'b1; run_frame();
        new_frame(9); set_len(2); f_abort_slot = 2; run_frame();

        // Illegal and maximum lengths.
        new_frame(8); set_len(0);  run_frame();
        new_frame(8); set_len(17); run_frame();
        new_frame(8); set_len(16); run_frame();

        // Asynchronous reset in the middle of the payload.
        new_frame(8);
        set_len(3);
        stop_slot = 5;
        stop_kind = K_NONE;
        drive_frame();
        chk("len_before_reset", int'(len_out), 3);
        @(posedge clk16);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk16);
        rst_n = 1'b1;
        @(negedge clk16);
        new_frame(8); set_len(2); run_frame();

        // Randomised frames.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      new_frame($urandom_range(1, 5));
            else if (r == 1) new_frame($urandom_range(12, 15));
            else             new_frame($urandom_range(6, 11));
            r = $urandom_range(0, 11);
            if (r == 0)      set_len(0);
            else if (r == 1) set_len(17);
            else if (r == 2) set_len($urandom_range(18, 255));
            else if (r == 3) set_len(16);
            else             set_len($urandom_range(1, 5));
            for (int i = 0; i < NSLOT; i++) begin
                if ($urandom_range(0, 59) == 0) f_serr[i] = 1'b1;
                if ($urandom_range(0, 9) == 0)  f_gap[i] = 15;
                if ($urandom_range(0, 79) == 0) f_gap[i] = $urandom_range(16, 18);
            end
            if ($urandom_range(0, 7) == 0) begin
                f_abort_slot = $urandom_range(0, 15);
                f_abort_sym  = 1'($urandom_range(0, 1));
            end
            run_frame();
        end

        chk("queue_empty_at_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
